prog_mem_loader: RTL and testbench
==================================

// Module: prog_mem_loader
// PURPOSE
//  Writer side of the program memory: receives a byte stream (valid/ready), packs it into
//  32-bit little-endian instructions and writes them into program memory from byte address 0.
//  Holds the RISC-V core in reset (cpu_hold) until a complete, checksum-valid image is loaded.
//  Stream format: 2-byte word count N (LE), 4*N instruction bytes, 1 XOR checksum byte.
// PARAMETERS
//  DEPTH      256  program memory size in 32-bit words; a load with N > DEPTH is rejected
//  CNT_WIDTH  16   width of the header word count and of loaded_words
// PORTS
//  clk           in   1   core clock; single clock domain
//  reset         in   1   synchronous, active-high reset
//  start         in   1   begin a load; sampled only in IDLE, DONE, ERR
//  byte_valid    in   1   byte_data valid
//  byte_data     in   8   stream byte
//  byte_ready    out  1   loader accepts byte_data this cycle
//  pm_we         out  1   program memory write strobe, one cycle per word
//  pm_waddr      out  64  byte address of the write (word index * 4)
//  pm_wdata      out  32  instruction word
//  cpu_hold      out  1   drives core reset; high unless state is DONE
//  done          out  1   image loaded and checksum matched (sticky)
//  error         out  1   oversize header or checksum mismatch (sticky)
//  loaded_words  out  16  words written in the current or last load
// BEHAVIOUR
//  - Reset: state IDLE; byte_ready=0, pm_we=0, pm_waddr=0, pm_wdata=0, cpu_hold=1, done=0,
//    error=0, loaded_words=0, checksum=0. Reset mid-load aborts at once; no partial write.
//  - Byte transfer happens only when byte_valid && byte_ready. byte_ready is a registered
//    function of state: 1 in HDR_LO, HDR_HI, DATA, CSUM; 0 otherwise.
//  - FSM: IDLE -start-> HDR_LO (clears done, error, loaded_words, checksum, byte index).
//    HDR_LO -byte-> HDR_HI (N[7:0]). HDR_HI -byte-> N[15:8]; then: N>DEPTH -> ERR;
//    N==0 -> CSUM; else DATA.
//    DATA: byte k goes into word bits [8k+7:8k]; checksum ^= byte; after 4th byte -> WRITE.
//    WRITE (exactly 1 cycle): pm_we=1, pm_waddr=idx<<2, pm_wdata=packed word; idx and
//    loaded_words += 1; -> CSUM if idx==N-1, else DATA.
//    CSUM -byte-> DONE if byte==checksum, else ERR.
//    DONE: done=1, cpu_hold=0. ERR: error=1, cpu_hold=1. Both persist until start or reset.
//  - start in HDR_*/DATA/WRITE/CSUM is ignored. Bytes offered while byte_ready=0 are not
//    consumed; the source holds them.
//  - Words already written before a checksum failure stay in memory; the core stays held.
//  - pm_waddr/pm_wdata hold their last value when pm_we=0. idx never wraps because N<=DEPTH.
//  - Latency: pm_we asserts the cycle after the 4th byte handshake; done asserts the cycle
//    after the checksum handshake.
// STRUCTURE
//  - Shared package: state encoding localparams (IDLE..ERR), header byte count and checksum
//    width constants, so the core testbench and the top level use the same values.
//  - One sub-module: word_packer (byte lane counter, 32-bit shift assembly, word_ready
//    pulse). FSM, counters and checksum stay in this module.
// TESTING
//  1 reset released, no start -> cpu_hold=1, byte_ready=0, done=0, error=0, pm_we never 1.
//  2 start; bytes 02 00 | 13 05 10 00 | 93 05 20 00 | B0 -> writes (0,0x00100513),
//    (4,0x00200593); done=1, cpu_hold=0, loaded_words=2.
//  3 same stream, checksum 00 -> both words written, error=1, done=0, cpu_hold=1.
//  4 header 01 01 (N=257 > DEPTH) -> error=1 the next cycle; no pm_we; byte_ready=0.
//  5 test 2 with byte_valid gaps plus a byte offered during WRITE -> byte held, not lost;
//    result identical to test 2.
//  6 reset after 3 DATA bytes -> IDLE, no write; then header 00 00, checksum 00 -> done=1,
//    loaded_words=0.

Source files
------------

// File: rtl/prog_mem_loader_pkg.sv
// Shared constants for the program memory loader: widths, stream framing and FSM state encoding.
package prog_mem_loader_pkg;

  localparam int unsigned DEPTH_DEF     = 256;
  localparam int unsigned CNT_WIDTH_DEF = 16;
  localparam int unsigned BYTE_W        = 8;
  localparam int unsigned WORD_W        = 32;
  localparam int unsigned ADDR_W        = 64;
  localparam int unsigned LANES         = WORD_W / BYTE_W;
  localparam int unsigned LANE_W        = 2;
  localparam int unsigned HDR_BYTES     = 2;
  localparam int unsigned CSUM_W        = 8;
  localparam int unsigned STATE_W       = 3;

  localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] ST_HDR_LO = 3'd1;
  localparam logic [STATE_W-1:0] ST_HDR_HI = 3'd2;
  localparam logic [STATE_W-1:0] ST_DATA   = 3'd3;
  localparam logic [STATE_W-1:0] ST_WRITE  = 3'd4;
  localparam logic [STATE_W-1:0] ST_CSUM   = 3'd5;
  localparam logic [STATE_W-1:0] ST_DONE   = 3'd6;
  localparam logic [STATE_W-1:0] ST_ERR    = 3'd7;

endpackage

// File: rtl/prog_mem_loader_word_packer.sv
// Assembles four stream bytes into a little-endian 32-bit word; flags the byte that completes it.
module prog_mem_loader_word_packer
  import prog_mem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              byte_en_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic [WORD_W-1:0] word_c,
  output logic              word_ready_c
);

  logic [LANE_W-1:0] lane_q, lane_d;
  logic [WORD_W-1:0] word_q, word_d;

  // Bytes enter at the top and shift down, so byte 0 ends up in bits [7:0].
  assign word_c       = {byte_i, word_q[WORD_W-1:BYTE_W]};
  assign word_ready_c = byte_en_i && (lane_q == LANE_W'(LANES - 1));

  always_comb begin
    lane_d = lane_q;
    word_d = word_q;
    if (clear_i) begin
      lane_d = '0;
      word_d = '0;
    end else if (byte_en_i) begin
      lane_d = lane_q + LANE_W'(1);
      word_d = word_c;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lane_q <= '0;
      word_q <= '0;
    end else begin
      lane_q <= lane_d;
      word_q <= word_d;
    end
  end

endmodule

// File: rtl/prog_mem_loader.sv
// Program memory writer: parses a counted, XOR-checksummed byte stream into 32-bit words
// and keeps the core in reset until a complete, valid image has been loaded.
module prog_mem_loader
  import prog_mem_loader_pkg::*;
#(
  parameter int unsigned DEPTH     = DEPTH_DEF,
  parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 byte_valid,
  input  logic [BYTE_W-1:0]    byte_data,
  output logic                 byte_ready,
  output logic                 pm_we,
  output logic [ADDR_W-1:0]    pm_waddr,
  output logic [WORD_W-1:0]    pm_wdata,
  output logic                 cpu_hold,
  output logic                 done,
  output logic                 error,
  output logic [CNT_WIDTH-1:0] loaded_words
);

  localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(DEPTH);

  logic [STATE_W-1:0]   state_q, state_d;
  logic [CNT_WIDTH-1:0] n_q, n_d;
  logic [CNT_WIDTH-1:0] idx_q, idx_d;
  logic [CNT_WIDTH-1:0] loaded_q, loaded_d;
  logic [CSUM_W-1:0]    csum_q, csum_d;
  logic                 byte_ready_q, byte_ready_d;
  logic                 pm_we_q, pm_we_d;
  logic [ADDR_W-1:0]    pm_waddr_q, pm_waddr_d;
  logic [WORD_W-1:0]    pm_wdata_q, pm_wdata_d;
  logic                 done_q, error_q, cpu_hold_q;

  logic                 hs;
  logic [CNT_WIDTH-1:0] hdr_n;
  logic                 pk_clear, pk_en;
  logic [WORD_W-1:0]    pk_word;
  logic                 pk_ready;

  assign hs    = byte_valid && byte_ready_q;
  assign hdr_n = CNT_WIDTH'({byte_data, n_q[BYTE_W-1:0]});

  prog_mem_loader_word_packer u_packer (
    .clk         (clk),
    .reset       (reset),
    .clear_i     (pk_clear),
    .byte_en_i   (pk_en),
    .byte_i      (byte_data),
    .word_c      (pk_word),
    .word_ready_c(pk_ready)
  );

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    idx_d      = idx_q;
    loaded_d   = loaded_q;
    csum_d     = csum_q;
    pm_we_d    = 1'b0;
    pm_waddr_d = pm_waddr_q;
    pm_wdata_d = pm_wdata_q;
    pk_clear   = 1'b0;
    pk_en      = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d  = ST_HDR_LO;
          n_d      = '0;
          idx_d    = '0;
          loaded_d = '0;
          csum_d   = '0;
          pk_clear = 1'b1;
        end
      end
      ST_HDR_LO: begin
        if (hs) begin
          n_d     = CNT_WIDTH'(byte_data);
          state_d = ST_HDR_HI;
        end
      end
      ST_HDR_HI: begin
        if (hs) begin
          n_d = hdr_n;
          if (hdr_n > DEPTH_C)      state_d = ST_ERR;
          else if (hdr_n == '0)     state_d = ST_CSUM;
          else                      state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (hs) begin
          pk_en  = 1'b1;
          csum_d = csum_q ^ byte_data;
          // The completing byte launches the write so pm_we lands in the WRITE cycle.
          if (pk_ready) begin
            state_d    = ST_WRITE;
            pm_we_d    = 1'b1;
            pm_waddr_d = ADDR_W'(idx_q) << 2;
            pm_wdata_d = pk_word;
          end
        end
      end
      ST_WRITE: begin
        idx_d    = idx_q + CNT_WIDTH'(1);
        loaded_d = loaded_q + CNT_WIDTH'(1);
        state_d  = (idx_q == n_q - CNT_WIDTH'(1)) ? ST_CSUM : ST_DATA;
      end
      ST_CSUM: begin
        if (hs) state_d = (byte_data == csum_q) ? ST_DONE : ST_ERR;
      end
      default: state_d = ST_IDLE;
    endcase
    byte_ready_d = (state_d == ST_HDR_LO) || (state_d == ST_HDR_HI) ||
                   (state_d == ST_DATA)   || (state_d == ST_CSUM);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      n_q          <= '0;
      idx_q        <= '0;
      loaded_q     <= '0;
      csum_q       <= '0;
      byte_ready_q <= 1'b0;
      pm_we_q      <= 1'b0;
      pm_waddr_q   <= '0;
      pm_wdata_q   <= '0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      cpu_hold_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      idx_q        <= idx_d;
      loaded_q     <= loaded_d;
      csum_q       <= csum_d;
      byte_ready_q <= byte_ready_d;
      pm_we_q      <= pm_we_d;
      pm_waddr_q   <= pm_waddr_d;
      pm_wdata_q   <= pm_wdata_d;
      done_q       <= (state_d == ST_DONE);
      error_q      <= (state_d == ST_ERR);
      cpu_hold_q   <= (state_d != ST_DONE);
    end
  end

  assign byte_ready   = byte_ready_q;
  assign pm_we        = pm_we_q;
  assign pm_waddr     = pm_waddr_q;
  assign pm_wdata     = pm_wdata_q;
  assign cpu_hold     = cpu_hold_q;
  assign done         = done_q;
  assign error        = error_q;
  assign loaded_words = loaded_q;

endmodule

// File: tb/tb_prog_mem_loader.sv
// Directed bench for prog_mem_loader: good/bad images, oversize header, stalls, reset abort.
module tb_prog_mem_loader;

  logic        clk = 1'b0;
  logic        reset, start, byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready, pm_we, cpu_hold, done, error;
  logic [63:0] pm_waddr;
  logic [31:0] pm_wdata;
  logic [15:0] loaded_words;

  int tests = 0;
  int fails = 0;

  logic [63:0] wr_addr[$];
  logic [31:0] wr_data[$];

  prog_mem_loader dut (
    .clk(clk), .reset(reset), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .pm_we(pm_we), .pm_waddr(pm_waddr), .pm_wdata(pm_wdata),
    .cpu_hold(cpu_hold), .done(done), .error(error), .loaded_words(loaded_words)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pm_we === 1'b1) begin
      wr_addr.push_back(pm_waddr);
      wr_data.push_back(pm_wdata);
    end
  end

  // All stimulus tasks run in the phase 1ns after a rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (byte_ready !== 1'b1 && n < 100) begin
      tick(1);
      n++;
    end
    tests++;
    if (n >= 100) begin
      fails++;
      $display("FAIL send_timeout: byte %h not accepted, byte_ready=%b", b, byte_ready);
    end
    tick(1);
    byte_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic check_two_writes(input string tag);
    tests++;
    if (wr_addr.size() != 2) begin
      fails++;
      $display("FAIL %s_wcount: got %0d writes, exp 2", tag, wr_addr.size());
    end else begin
      if (wr_addr[0] !== 64'd0 || wr_data[0] !== 32'h00100513) begin
        fails++;
        $display("FAIL %s_w0: got (%0h,%h) exp (0,00100513)", tag, wr_addr[0], wr_data[0]);
      end
      tests++;
      if (wr_addr[1] !== 64'd4 || wr_data[1] !== 32'h00200593) begin
        fails++;
        $display("FAIL %s_w1: got (%0h,%h) exp (4,00200593)", tag, wr_addr[1], wr_data[1]);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    tick(3);
    reset = 1'b0;
    byte_valid = 1'b1; byte_data = 8'h55;
    tick(6);
    byte_valid = 1'b0;
    tests++;
    if ({cpu_hold, byte_ready, done, error, pm_we} !== 5'b10000) begin
      fails++;
      $display("FAIL reset_flags: got hold/rdy/done/err/we=%b exp 10000",
               {cpu_hold, byte_ready, done, error, pm_we});
    end
    tests++;
    if (pm_waddr !== 64'd0 || pm_wdata !== 32'd0 || loaded_words !== 16'd0) begin
      fails++;
      $display("FAIL reset_regs: got addr=%0h data=%h lw=%0d exp 0/0/0", pm_waddr, pm_wdata, loaded_words);
    end
    tests++;
    if (wr_addr.size() != 0) begin
      fails++;
      $display("FAIL reset_nowrite: got %0d writes exp 0", wr_addr.size());
    end
  endtask

  task automatic test_good_load();
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h05); send_byte(8'h10); send_byte(8'h00);
    tests++;
    if (pm_we !== 1'b1 || pm_waddr !== 64'd0 || pm_wdata !== 32'h00100513) begin
      fails++;
      $display("FAIL good_we_latency: got we=%b addr=%0h data=%h exp 1/0/00100513", pm_we, pm_waddr, pm_wdata);
    end
    send_byte(8'h93); send_byte(8'h05); send_byte(8'h20); send_byte(8'h00);
    send_byte(8'hB0);
    tests++;
    if (done !== 1'b1 || cpu_hold !== 1'b0 || error !== 1'b0 || loaded_words !== 16'd2) begin
      fails++;
      $display("FAIL good_status: got done=%b hold=%b err=%b lw=%0d exp 1/0/0/2", done, cpu_hold, error, loaded_words);
    end
    check_two_writes("good");
    tick(3);
    tests++;
    if (pm_we !== 1'b0 || pm_wdata !== 32'h00200593 || pm_waddr !== 64'd4 || done !== 1'b1) begin
      fails++;
      $display("FAIL good_hold: got we=%b addr=%0h data=%h done=%b exp 0/4/00200593/1", pm_we, pm_waddr, pm_wdata, done);
    end
  endtask

  task automatic test_bad_checksum();
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    tests++;
    if (done !== 1'b0 || loaded_words !== 16'd0 || cpu_hold !== 1'b1 || byte_ready !== 1'b1) begin
      fails++;
      $display("FAIL restart_clear: got done=%b lw=%0d hold=%b rdy=%b exp 0/0/1/1", done, loaded_words, cpu_hold, byte_ready);
    end
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h05); send_byte(8'h10); send_byte(8'h00);
    send_byte(8'h93); send_byte(8'h05); send_byte(8'h20); send_byte(8'h00);
    send_byte(8'h00);
    tests++;
    if (error !== 1'b1 || done !== 1'b0 || cpu_hold !== 1'b1 || loaded_words !== 16'd2) begin
      fails++;
      $display("FAIL badcs_status: got err=%b done=%b hold=%b lw=%0d exp 1/0/1/2", error, done, cpu_hold, loaded_words);
    end
    check_two_writes("badcs");
  endtask

  task automatic test_oversize();
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    tests++;
    if (error !== 1'b0) begin
      fails++;
      $display("FAIL over_errclr: got err=%b exp 0", error);
    end
    send_byte(8'h01); send_byte(8'h01);
    tests++;
    if (error !== 1'b1 || byte_ready !== 1'b0 || cpu_hold !== 1'b1) begin
      fails++;
      $display("FAIL over_status: got err=%b rdy=%b hold=%b exp 1/0/1", error, byte_ready, cpu_hold);
    end
    byte_valid = 1'b1; byte_data = 8'hAA;
    tick(4);
    byte_valid = 1'b0;
    tests++;
    if (wr_addr.size() != 0 || error !== 1'b1) begin
      fails++;
      $display("FAIL over_nowrite: got %0d writes err=%b exp 0/1", wr_addr.size(), error);
    end
  endtask

  task automatic test_gaps();
    logic [7:0] s [11];
    s = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00, 8'hB0};
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    for (int i = 0; i < 11; i++) begin
      tick(i % 3);
      // A start pulse mid-stream must not restart the load.
      if (i == 4) pulse_start();
      send_byte(s[i]);
    end
    tests++;
    if (done !== 1'b1 || cpu_hold !== 1'b0 || error !== 1'b0 || loaded_words !== 16'd2) begin
      fails++;
      $display("FAIL gaps_status: got done=%b hold=%b err=%b lw=%0d exp 1/0/0/2", done, cpu_hold, error, loaded_words);
    end
    check_two_writes("gaps");
  endtask

  task automatic test_reset_abort();
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h05); send_byte(8'h10);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(3);
    tests++;
    if (wr_addr.size() != 0 || byte_ready !== 1'b0 || cpu_hold !== 1'b1 || done !== 1'b0 || loaded_words !== 16'd0) begin
      fails++;
      $display("FAIL abort_state: got wr=%0d rdy=%b hold=%b done=%b lw=%0d exp 0/0/1/0/0",
               wr_addr.size(), byte_ready, cpu_hold, done, loaded_words);
    end
    pulse_start();
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    tests++;
    if (done !== 1'b1 || cpu_hold !== 1'b0 || loaded_words !== 16'd0 || wr_addr.size() != 0) begin
      fails++;
      $display("FAIL empty_load: got done=%b hold=%b lw=%0d wr=%0d exp 1/0/0/0", done, cpu_hold, loaded_words, wr_addr.size());
    end
  endtask

  task automatic test_single_word();
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
    send_byte(8'h22);
    tests++;
    if (done !== 1'b1 || loaded_words !== 16'd1 || wr_data.size() != 1) begin
      fails++;
      $display("FAIL single_status: got done=%b lw=%0d wr=%0d exp 1/1/1", done, loaded_words, wr_data.size());
    end else begin
      tests++;
      if (wr_addr[0] !== 64'd0 || wr_data[0] !== 32'hDEADBEEF) begin
        fails++;
        $display("FAIL single_word: got (%0h,%h) exp (0,deadbeef)", wr_addr[0], wr_data[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_good_load();
    test_bad_checksum();
    test_oversize();
    test_gaps();
    test_reset_abort();
    test_single_word();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
